// File: rtl/slow_mult.sv
// Sequential shift-and-add unsigned multiplier that retires one multiplier bit per clock.
// Optional build macro SLOW_MULT_EARLY_EXIT_EN ends the operation once the remaining multiplier bits are zero.
module slow_mult #(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DW-1:0]     multiplicand,
    input  logic [DW-1:0]     multiplier,
    output logic              busy,
    output logic              valid,
    output logic [2*DW-1:0]   product
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r;
    logic [2*DW-1:0]  a_r;
    logic [DW-1:0]    b_r;
    logic [2*DW-1:0]  acc_r;
    logic [CW-1:0]    cnt_r;
    logic [2*DW-1:0]  sum_s;
    logic             last_s;

    // Conditional add of the shifted multiplicand; 2*DW bits always hold the full product.
    function automatic logic [2*DW-1:0] add_step(
        input logic [2*DW-1:0] acc,
        input logic [2*DW-1:0] addend,
        input logic            sel
    );
        if (sel) begin
            return acc + addend;
        end else begin
            return acc;
        end
    endfunction

    // Partial sum for this iteration and detection of the completing iteration.
    always_comb begin
        sum_s  = add_step(acc_r, a_r, b_r[0]);
        last_s = 1'b0;
`ifdef SLOW_MULT_EARLY_EXIT_EN
        if ((cnt_r == CW'(DW - 1)) || (b_r[DW-1:1] == '0)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
`else
        if (cnt_r == CW'(DW - 1)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
`endif
    end

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            acc_r   <= '0;
            cnt_r   <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            product <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        a_r     <= {{DW{1'b0}}, multiplicand};
                        b_r     <= multiplier;
                        acc_r   <= '0;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (last_s) begin
                        product <= sum_s;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                        acc_r   <= '0;
                        cnt_r   <= '0;
                        state_r <= IDLE;
                    end else begin
                        acc_r   <= sum_s;
                        a_r     <= a_r << 1;
                        b_r     <= b_r >> 1;
                        cnt_r   <= cnt_r + CW'(1);
                        valid   <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    valid   <= 1'b0;
                end
            endcase
        end
    end

    slow_mult_checker u_checker (
        .clk   (clk),
        .rst   (rst),
        .busy  (busy),
        .valid (valid)
    );

endmodule

// Handshake invariants: busy and valid are exclusive, valid is a single-cycle pulse.
module slow_mult_checker (
    input logic clk,
    input logic rst,
    input logic busy,
    input logic valid
);

    a_exclusive: assert property (@(posedge clk) disable iff (rst) !(busy && valid));
    a_pulse:     assert property (@(posedge clk) disable iff (rst) valid |=> !valid);

endmodule

// File: tb/tb_slow_mult.sv
// Self-checking bench for slow_mult (DW=8): vector table, scoreboard of expected products and completion cycles.
module tb_slow_mult;

    localparam int DW = 8;

    logic            clk;
    logic            rst;
    logic            start;
    logic [DW-1:0]   multiplicand;
    logic [DW-1:0]   multiplier;
    logic            busy;
    logic            valid;
    logic [2*DW-1:0] product;

    typedef struct {
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        logic [2*DW-1:0] prod;
    } vec_t;

    typedef struct {
        logic [2*DW-1:0] prod;
        int              cyc;
    } exp_t;

    exp_t            sb[$];
    vec_t            vecs[8];
    int              checks;
    int              failures;
    int              cyc;
    logic [2*DW-1:0] last_exp;

    slow_mult #(.DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .valid        (valid),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input logic [DW-1:0] b);
`ifdef SLOW_MULT_EARLY_EXIT_EN
        for (int i = DW - 1; i >= 0; i--) begin
            if (b[i]) return i + 1;
        end
        return 1;
`else
        return DW;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive a one-cycle start pulse at the current negedge; push expectation when it should be accepted.
    task automatic pulse(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit accept);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        if (accept) sb.push_back('{prod: 16'(a) * 16'(b), cyc: cyc + 1 + lat(b)});
        @(negedge clk);
        start        = 1'b0;
        multiplicand = $urandom_range(0, 255);
        multiplier   = $urandom_range(0, 255);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk({name, "_timeout"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        cyc          = 0;
        last_exp     = '0;
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        vecs[0] = '{a: 8'd13,  b: 8'd11,  prod: 16'd143};
        vecs[1] = '{a: 8'd255, b: 8'd255, prod: 16'd65025};
        vecs[2] = '{a: 8'd0,   b: 8'd200, prod: 16'd0};
        vecs[3] = '{a: 8'd77,  b: 8'd0,   prod: 16'd0};
        vecs[4] = '{a: 8'd1,   b: 8'd1,   prod: 16'd1};
        vecs[5] = '{a: 8'd200, b: 8'd128, prod: 16'd25600};
        vecs[6] = '{a: 8'd128, b: 8'd3,   prod: 16'd384};
        vecs[7] = '{a: 8'd37,  b: 8'd41,  prod: 16'd1517};

        fork
            // Scoreboard monitor: every valid must match the oldest pending expectation, product holds otherwise.
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (busy && valid) chk("busy_valid_exclusive", 32'd1, 32'd0);
                    if (valid) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_valid", 32'd1, 32'd0);
                        end else begin
                            exp_t e;
                            e = sb.pop_front();
                            chk("product", 32'(product), 32'(e.prod));
                            chk("latency_cycle", 32'(cyc), 32'(e.cyc));
                            last_exp = e.prod;
                        end
                    end else begin
                        chk("product_hold", 32'(product), 32'(last_exp));
                    end
                end
            end
        join_none

        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_product", 32'(product), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table vectors: each product is compared against the constant, one operation at a time.
        for (int i = 0; i < 8; i++) begin
            chk("table_model", 32'(16'(vecs[i].a) * 16'(vecs[i].b)), 32'(vecs[i].prod));
            start        = 1'b1;
            multiplicand = vecs[i].a;
            multiplier   = vecs[i].b;
            sb.push_back('{prod: vecs[i].prod, cyc: cyc + 1 + lat(vecs[i].b)});
            @(negedge clk);
            start = 1'b0;
            chk("busy_after_accept", 32'(busy), 32'd1);
            drain("table");
            repeat (2) @(negedge clk);
        end

        // Start while busy is ignored: 6x7 runs, the 3x5 request at cycle 4 must leave no trace.
        @(negedge clk);
        pulse(8'd6, 8'd7, 1'b1);
        repeat (2) @(negedge clk);
        pulse(8'd3, 8'd5, 1'b0);
        drain("ignored_start");
        repeat (12) @(negedge clk);

        // Reset mid-operation clears outputs immediately and suppresses the result.
        pulse(8'd250, 8'd251, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_product", 32'(product), 32'd0);
        sb.delete();
        last_exp = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        pulse(8'd9, 8'd9, 1'b1);
        drain("after_reset");
        @(negedge clk);

        // Back-to-back: each new start is driven in the cycle the previous valid is visible.
        pulse(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
        for (int k = 1; k < 10; k++) begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 40 && !seen; t++) begin
                if (valid) begin
                    seen = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
            chk("b2b_valid_seen", 32'(seen), 32'd1);
            pulse(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 1'b1);
        end
        drain("b2b");
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
